// File: rtl/regfile_write_queue.sv
// Write-back queue for the 32x32 regfile; two producers (mem, ALU) in, one regfile write per cycle out.
// Latency: accept at edge N -> RegWrite visible after edge N+1; readies come from the registered count only.
// Backpressure: Mem accepted while a slot is free, ALU while two are free; WQ_PENDING_EN compiles the RAW-hazard comparators.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluAddr,
  input  logic [DATA_W-1:0] AluData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              Pending1,
  output logic              Pending2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, alu_ptr;
  logic [CW-1:0]     count;
  logic              push_mem, push_alu, pop;

  assign MemReady = Reset_n && (count <= CW'(DEPTH - 1));
  assign AluReady = Reset_n && (count <= CW'(DEPTH - 2));

  // r0 writes complete the handshake but never occupy a slot
  assign push_mem = MemValid && MemReady && (MemAddr != '0);
  assign push_alu = AluValid && AluReady && (AluAddr != '0);
  assign pop      = (count != '0);
  assign alu_ptr  = wr_ptr + PW'(push_mem);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      count    <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
      wr_ptr   <= wr_ptr + PW'(push_mem) + PW'(push_alu);
      rd_ptr   <= rd_ptr + PW'(pop);
      RegWrite <= pop;
      if (pop) begin
        WriteRegister <= addr_q[rd_ptr];
        WriteData     <= data_q[rd_ptr];
      end
    end
  end

  // Mem lands first so an ALU write to the same register retires last
  always_ff @(posedge Clk) begin
    if (push_mem) begin
      addr_q[wr_ptr] <= MemAddr;
      data_q[wr_ptr] <= MemData;
    end
    if (push_alu) begin
      addr_q[alu_ptr] <= AluAddr;
      data_q[alu_ptr] <= AluData;
    end
  end

`ifdef WQ_PENDING_EN
  logic hit1, hit2;

  always_comb begin
    hit1 = RegWrite && (WriteRegister == ReadRegister1);
    hit2 = RegWrite && (WriteRegister == ReadRegister2);
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (addr_q[rd_ptr + PW'(i)] == ReadRegister1) hit1 = 1'b1;
        if (addr_q[rd_ptr + PW'(i)] == ReadRegister2) hit2 = 1'b1;
      end
    end
  end

  assign Pending1 = hit1 && (ReadRegister1 != '0);
  assign Pending2 = hit2 && (ReadRegister2 != '0);
`else
  logic unused_rd;
  assign unused_rd = ^{ReadRegister1, ReadRegister2};
  assign Pending1  = 1'b0;
  assign Pending2  = 1'b0;
`endif

endmodule
